// File: rtl/traf_pkg.sv
// rtl/traf_pkg.sv - shared light encodings and controller state codes
// Contents: light_t (RED/YELLOW/GREEN), state_t (phase codes 0..5), LIGHT_W.
package traf_pkg;

  localparam int LIGHT_W = 2;

  typedef enum logic [LIGHT_W-1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5
  } state_t;

endpackage

// File: rtl/traf_rr_arb.sv
// rtl/traf_rr_arb.sv - combinational cyclic search for the next side road to serve
// Ports:
//   pending [NUM_ROADS-1:0] in  : per-road waiting flags (bit 0 never considered)
//   rr_ptr  [SEL_W-1:0]     in  : first road examined (1..NUM_ROADS-1)
//   sel     [SEL_W-1:0]     out : first pending road at or after rr_ptr, wrapping 1..NUM_ROADS-1
//   valid                   out : some side road is pending
module traf_rr_arb
  import traf_pkg::*;
#(
  parameter int NUM_ROADS = 4,
  parameter int SEL_W     = 2
) (
  input  logic [NUM_ROADS-1:0] pending,
  input  logic [SEL_W-1:0]     rr_ptr,
  output logic [SEL_W-1:0]     sel,
  output logic                 valid
);

  int idx;

  // Walk the side roads starting at rr_ptr; road 0 is outside the ring.
  always_comb begin
    sel   = SEL_W'(1);
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_ROADS - 1; k++) begin
      idx = ((int'(rr_ptr) - 1 + k) % (NUM_ROADS - 1)) + 1;
      if (!valid && pending[idx]) begin
        valid = 1'b1;
        sel   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_road_traf_cont.sv
// rtl/multi_road_traf_cont.sv - main-road-priority traffic controller for NUM_ROADS approaches
// Ports:
//   clock                      in  : rising-edge clock
//   clear                      in  : synchronous active-low reset
//   car_req [NUM_ROADS-1:0]    in  : vehicle sensors, bit 0 (main road) ignored
//   emerg                      in  : emergency preempt (only with EMERG_PREEMPT_EN defined)
//   sig [2*NUM_ROADS-1:0]      out : light per road, road i at [2i+1:2i]
//   phase [2:0]                out : current state code
// Optional feature macro: EMERG_PREEMPT_EN
module multi_road_traf_cont
  import traf_pkg::*;
#(
  parameter int NUM_ROADS = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [NUM_ROADS-1:0]         car_req,
`ifdef EMERG_PREEMPT_EN
  input  logic                         emerg,
`endif
  output logic [LIGHT_W*NUM_ROADS-1:0] sig,
  output logic [2:0]                   phase
);

  localparam int SEL_W = $clog2(NUM_ROADS);
  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_SAT  = '1;

  state_t               state, state_n;
  logic [CNT_W-1:0]     timer;
  logic [NUM_ROADS-1:0] pending, pending_n;
  logic [SEL_W-1:0]     sel, sel_n, rr_ptr, rr_ptr_n, arb_sel;
  logic                 arb_valid;
  logic                 emerg_act;

`ifdef EMERG_PREEMPT_EN
  assign emerg_act = emerg;
`else
  assign emerg_act = 1'b0;
`endif

  traf_rr_arb #(
    .NUM_ROADS (NUM_ROADS),
    .SEL_W     (SEL_W)
  ) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .sel     (arb_sel),
    .valid   (arb_valid)
  );

  function automatic logic [LIGHT_W*NUM_ROADS-1:0] decode(state_t s, logic [SEL_W-1:0] r);
    logic [LIGHT_W*NUM_ROADS-1:0] v;
    v = '0;
    case (s)
      MAIN_G:  v[LIGHT_W-1:0] = GREEN;
      MAIN_Y:  v[LIGHT_W-1:0] = YELLOW;
      SIDE_G:  v[LIGHT_W*int'(r) +: LIGHT_W] = GREEN;
      SIDE_Y:  v[LIGHT_W*int'(r) +: LIGHT_W] = YELLOW;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    rr_ptr_n = rr_ptr;
    case (state)
      MAIN_G: if (!emerg_act && arb_valid && timer >= T_GMIN) begin
        state_n  = MAIN_Y;
        sel_n    = arb_sel;
        rr_ptr_n = (arb_sel == SEL_W'(NUM_ROADS - 1)) ? SEL_W'(1) : arb_sel + SEL_W'(1);
      end
      MAIN_Y: if (timer == T_YEL) state_n = ALL_R1;
      // Preempt diverts to the second all-red so the side road is never opened.
      ALL_R1: if (timer == T_AR) state_n = emerg_act ? ALL_R2 : SIDE_G;
      SIDE_G: if (emerg_act || timer == T_GMAX || (timer >= T_GMIN && !car_req[sel]))
        state_n = SIDE_Y;
      SIDE_Y: if (timer == T_YEL) state_n = ALL_R2;
      ALL_R2: if (timer == T_AR) state_n = MAIN_G;
      default: state_n = MAIN_G;
    endcase

    pending_n    = pending;
    pending_n[0] = 1'b0;
    for (int i = 1; i < NUM_ROADS; i++) begin
      if (car_req[i] && !(state == SIDE_G && sel == SEL_W'(i))) pending_n[i] = 1'b1;
    end
    // Service start clears the request; ordered last so it beats a same-cycle set.
    if (state_n == SIDE_G && state != SIDE_G) pending_n[sel_n] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= MAIN_G;
      timer   <= '0;
      pending <= '0;
      sel     <= SEL_W'(1);
      rr_ptr  <= SEL_W'(1);
      sig     <= decode(MAIN_G, SEL_W'(1));
      phase   <= MAIN_G;
    end else begin
      state   <= state_n;
      // Saturate so an idle main green cannot wrap below the minimum-green threshold.
      timer   <= (state_n != state) ? '0 : ((timer == T_SAT) ? timer : timer + CNT_W'(1));
      pending <= pending_n;
      sel     <= sel_n;
      rr_ptr  <= rr_ptr_n;
      sig     <= decode(state_n, sel_n);
      phase   <= state_n;
    end
  end

endmodule

// File: tb/tb_multi_road_traf_cont.sv
// tb/tb_multi_road_traf_cont.sv - self-checking bench for multi_road_traf_cont
module tb_multi_road_traf_cont;

  localparam int NR   = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 3;
  localparam int AT   = 2;

  logic          clock = 1'b0;
  logic          clr   = 1'b0;
  logic [NR-1:0] cr    = '0;
  logic          em    = 1'b0;
  logic [2*NR-1:0] sig;
  logic [2:0]    phase;

  int checks = 0;
  int errors = 0;

  // Reference model: phase code, cycles spent in phase, served road, next search start.
  int ms, mt, msel, mrr;
  bit mp [NR];

  always #5 clock = ~clock;

  multi_road_traf_cont #(
    .NUM_ROADS (NR), .GREEN_MIN (GMIN), .GREEN_MAX (GMAX),
    .YELLOW_T (YT), .ALLRED_T (AT), .CNT_W (8)
  ) dut (
    .clock   (clock),
    .clear   (clr),
    .car_req (cr),
`ifdef EMERG_PREEMPT_EN
    .emerg   (em),
`endif
    .sig     (sig),
    .phase   (phase)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NR-1:0] model_sig();
    logic [2*NR-1:0] v;
    v = '0;
    if (ms == 0) v[1:0] = 2'd2;
    if (ms == 1) v[1:0] = 2'd1;
    if (ms == 3) v[2*msel +: 2] = 2'd2;
    if (ms == 4) v[2*msel +: 2] = 2'd1;
    return v;
  endfunction

  task automatic model_step();
    int nxt, cand;
    bit any;
    if (!clr) begin
      ms = 0; mt = 0; msel = 1; mrr = 1;
      foreach (mp[i]) mp[i] = 1'b0;
      return;
    end
    nxt = ms;
    any = 1'b0;
    for (int i = 1; i < NR; i++) any |= mp[i];
    case (ms)
      0: if (!em && any && mt >= GMIN - 1) begin
        nxt = 1;
        cand = 0;
        for (int k = 0; k < NR - 1; k++)
          if (cand == 0 && mp[1 + (mrr - 1 + k) % (NR - 1)]) cand = 1 + (mrr - 1 + k) % (NR - 1);
        msel = cand;
        mrr  = cand % (NR - 1) + 1;
      end
      1: if (mt == YT - 1) nxt = 2;
      2: if (mt == AT - 1) nxt = em ? 5 : 3;
      3: if (em || mt == GMAX - 1 || (mt >= GMIN - 1 && !cr[msel])) nxt = 4;
      4: if (mt == YT - 1) nxt = 5;
      default: if (mt == AT - 1) nxt = 0;
    endcase
    for (int i = 1; i < NR; i++)
      if (cr[i] && !(ms == 3 && msel == i)) mp[i] = 1'b1;
    if (nxt == 3 && ms != 3) mp[msel] = 1'b0;
    mt = (nxt != ms) ? 0 : mt + 1;
    ms = nxt;
  endtask

  task automatic tick();
    int lit;
    @(posedge clock);
    model_step();
    #1;
    check("phase", phase, ms);
    check("sig", sig, model_sig());
    lit = 0;
    for (int i = 0; i < NR; i++) if (sig[2*i +: 2] != 2'd0) lit++;
    check("one_road_lit", lit <= 1, 1);
  endtask

  task automatic do_reset();
    clr = 1'b0; cr = '0; em = 1'b0;
    tick();
    clr = 1'b1;
  endtask

  task automatic wait_phase(int target, string tag);
    int n = 0;
    while (phase != 3'(target) && n < 200) begin tick(); n++; end
    check(tag, phase, target);
  endtask

  task automatic count_phase(int p, output int n);
    n = 0;
    while (phase == 3'(p) && n < 300) begin n++; tick(); end
  endtask

  function automatic int green_road();
    for (int i = 0; i < NR; i++) if (sig[2*i +: 2] == 2'd2) return i;
    return -1;
  endfunction

  int seq34 [20] = '{0,0,0,0,1,1,1,2,2,3,3,3,3,4,4,4,5,5,0,0};
  int n, road;

  initial begin
    // Idle: main road green, no requests.
    do_reset();
    check("reset_sig", sig, 8'b00_00_00_10);
    check("reset_phase", phase, 0);
    check("reset_pending", dut.pending, 0);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_sig", sig, 8'b00_00_00_10);
      check("idle_phase", phase, 0);
    end

    // Single pulse on road 2: full cycle timeline.
    do_reset();
    for (int k = 1; k < 20; k++) begin
      cr = (k == 1) ? 4'b0100 : 4'b0000;
      tick();
      check("pulse2_timeline", phase, seq34[k]);
      if (phase == 3'd3) check("pulse2_road", green_road(), 2);
    end

    // Road 1 held: capped green, re-served after minimum main green.
    do_reset();
    cr = 4'b0010;
    wait_phase(3, "held1_first_green");
    count_phase(3, n);
    check("held1_green_len", n, GMAX);
    wait_phase(0, "held1_back_main");
    count_phase(0, n);
    check("held1_main_min", n >= GMIN, 1);
    wait_phase(3, "held1_second_green");
    check("held1_second_road", green_road(), 1);
    count_phase(3, n);
    check("held1_green_len2", n, GMAX);
    cr = '0;

    // All side roads at once: round-robin order with main green between.
    do_reset();
    cr = 4'b1110;
    tick();
    cr = '0;
    for (int r = 1; r < NR; r++) begin
      wait_phase(3, "rr_green");
      check("rr_order", green_road(), r);
      count_phase(3, n);
      check("rr_green_len", n, GMIN);
      wait_phase(0, "rr_main");
      count_phase(0, n);
      if (r < NR - 1) check("rr_main_min", n >= GMIN, 1);
    end

    // Reset during side yellow aborts immediately.
    do_reset();
    cr = 4'b1000;
    tick();
    cr = 4'b1010;
    wait_phase(4, "abort_reach_sidey");
    clr = 1'b0;
    tick();
    check("abort_phase", phase, 0);
    check("abort_sig", sig, 8'b00_00_00_10);
    check("abort_pending", dut.pending, 0);
    clr = 1'b1;
    cr = '0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_stays_main", phase, 0);

`ifdef EMERG_PREEMPT_EN
    // Preempt during road 3 green at timer 1.
    do_reset();
    cr = 4'b1000;
    tick();
    cr = '0;
    wait_phase(3, "emerg_reach_g3");
    check("emerg_road3", green_road(), 3);
    tick();
    em = 1'b1;
    tick();
    check("emerg_to_sidey", phase, 4);
    for (int i = 0; i < 3; i++) tick();
    check("emerg_to_allr2", phase, 5);
    tick();
    tick();
    check("emerg_to_main", phase, 0);
    cr = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("emerg_hold_main", phase, 0);
    end
    em = 1'b0;
    cr = '0;
    wait_phase(3, "emerg_release_serves");
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cr  = NR'($urandom) & NR'($urandom);
      clr = ($urandom_range(0, 199) != 0);
`ifdef EMERG_PREEMPT_EN
      if ($urandom_range(0, 39) == 0) em = ~em;
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_road_traf_cont.md
MULTI_ROAD_TRAF_CONT -- requirements
Module: multi_road_traf_cont

Interface
REQ-001 Parameter NUM_ROADS, default 4: number of approaches (2..8); road 0 is the main road.
REQ-002 Parameter GREEN_MIN, default 4: minimum green length in cycles (>=1).
REQ-003 Parameter GREEN_MAX, default 10: maximum side-road green length in cycles (>=GREEN_MIN, <2**CNT_W).
REQ-004 Parameters YELLOW_T, default 3, and ALLRED_T, default 2: yellow and all-red lengths in cycles (each >=1).
REQ-005 Parameter CNT_W, default 8: phase timer width.
REQ-006 clock  input  1  sole clock; all state changes on its rising edge.
REQ-007 clear  input  1  reset; synchronous and active-low.
REQ-008 car_req  input  NUM_ROADS  per-road vehicle sensor, active-high; bit 0 is ignored.
REQ-009 sig  output  2*NUM_ROADS  light of road i at bits [2i+1:2i]: RED=0, YELLOW=1, GREEN=2.
REQ-010 phase  output  3  current state code, for status and debug.
REQ-011 emerg  input  1  emergency preempt, active-high; present only with EMERG_PREEMPT_EN.

Function
REQ-012 States and phase codes: MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5.
REQ-013 sig and phase shall decode from registered state only (Moore); they are valid right after the edge that enters a state.
REQ-014 Road 0 is GREEN in MAIN_G and YELLOW in MAIN_Y; road sel is GREEN in SIDE_G and YELLOW in SIDE_Y; every other road is RED at all times.
REQ-015 The timer clears on each state entry and increments every cycle while in that state.
REQ-016 pending[i] (i>=1) sets on any cycle where car_req[i]=1 and road i is not GREEN.
REQ-017 pending[i] clears on entry to SIDE_G with sel=i; the clear wins over a same-cycle set.
REQ-018 MAIN_G->MAIN_Y when timer>=GREEN_MIN-1 and any pending bit is set; otherwise the main road stays green indefinitely.
REQ-019 On the MAIN_G->MAIN_Y edge, sel latches the first pending road found by a cyclic search over 1..NUM_ROADS-1 starting at rr_ptr.
REQ-020 On the same edge, rr_ptr becomes sel+1, wrapping from NUM_ROADS-1 to 1.
REQ-021 MAIN_Y lasts exactly YELLOW_T cycles, ALL_R1 exactly ALLRED_T cycles, then SIDE_G.
REQ-022 SIDE_G->SIDE_Y when either (timer>=GREEN_MIN-1 and car_req[sel]=0) or timer=GREEN_MAX-1.
REQ-023 SIDE_Y lasts exactly YELLOW_T cycles, ALL_R2 exactly ALLRED_T cycles, then MAIN_G; side-to-side transfer without main green is forbidden.
REQ-024 No two roads shall ever be GREEN or YELLOW simultaneously.

Reset
REQ-025 clear=0 at a rising edge, in any state: state=MAIN_G, timer=0, pending=0, sel=1, rr_ptr=1 after that edge.
REQ-026 Reset values: sig = road 0 GREEN, all others RED; phase=0.
REQ-027 Reset mid-phase (e.g. during SIDE_Y) shall abort the phase with no yellow or all-red completion.

Configuration
REQ-028 Macro EMERG_PREEMPT_EN defined: emerg port exists.
REQ-029 With emerg=1: MAIN_G shall not exit; SIDE_G->SIDE_Y on the next edge regardless of timer; ALL_R1 exits to ALL_R2 instead of SIDE_G, leaving pending and rr_ptr unchanged.
REQ-030 Macro undefined: no emerg port, and behaviour equals emerg tied to 0.

Structure
REQ-031 Package traf_pkg holds the light encodings (RED/YELLOW/GREEN), the state enum with the phase codes, and the light-field width constant 2.
REQ-032 Sub-module traf_rr_arb (pending vector plus rr_ptr in, sel and valid out, combinational) implements the cyclic search; the top holds the FSM, timer, pending, sel and rr_ptr.

Verification (defaults: NUM_ROADS=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2)
REQ-033 Reset, then no requests for 50 cycles -> sig=8'b00_00_00_10 and phase=0 throughout.
REQ-034 One-cycle pulse on car_req[2] at cycle 1 after reset -> main green 4 cycles, then road-0 yellow 3, all-red 2, road-2 green 4, road-2 yellow 3, all-red 2, then MAIN_G.
REQ-035 car_req[1] held high continuously -> road-1 green exactly 10 cycles; pending[1] re-sets, so the next cycle serves road 1 again after at least 4 cycles of main green.
REQ-036 car_req[1], car_req[2] and car_req[3] all pulsed together -> side roads served in order 1, 2, 3, with a main green of at least 4 cycles between each.
REQ-037 clear driven low during SIDE_Y -> on the next edge phase=0, road 0 GREEN, pending=0.
REQ-038 With EMERG_PREEMPT_EN: emerg raised during road-3 green at timer=1 -> SIDE_Y on the next edge, then ALL_R2, then MAIN_G, held while emerg=1.
